tt_sum_accumulator: RTL
=======================

// Module: tt_sum_accumulator
// PURPOSE
//   Downstream stage of the 9-bit operand adder in the TT07 top. Consumes the
//   adder's sum stream under a valid/ready handshake and accumulates BURST
//   consecutive samples into a wider result. Presents the result behind a
//   registered valid/ready output and reports overflow. Lets the top drive
//   uo_out from a held, burst-integrated value instead of the raw sum.
// PARAMETERS
//   IN_W      9    width of sum_in (matches adder output)
//   ACC_W     11   accumulator / result width, ACC_W >= IN_W
//   BURST     4    samples per result, legal range 2..255
//   SATURATE  1    1: clamp to all-ones on overflow; 0: wrap modulo 2^ACC_W
// PORTS
//   clk         in   1      clock, all state on rising edge
//   rst_n       in   1      asynchronous active-low reset
//   ena         in   1      design enable; 0 freezes all state
//   clear       in   1      synchronous abort: drop burst, restart accumulation
//   sum_in      in   IN_W   unsigned sample from the adder
//   in_valid    in   1      sum_in valid this cycle
//   in_ready    out  1      block accepts a sample this cycle
//   acc_out     out  ACC_W  accumulated value (running in ACCUM, final in HOLD)
//   out_valid   out  1      acc_out is a completed burst result
//   out_ready   in   1      consumer takes the result
//   overflow    out  1      sticky: current burst exceeded 2^ACC_W-1
//   sample_cnt  out  8      samples accepted in current burst
// BEHAVIOUR
//   Reset (rst_n=0, async): state=ACCUM, acc_out=0, sample_cnt=0,
//     out_valid=0, overflow=0. in_ready is combinational, so reads 1 whenever
//     ena=1, even while rst_n=0. All outputs take effect without waiting for clk.
//   in_ready = ena & (state==ACCUM) & ~clear. Combinational; never depends on in_valid.
//   States:
//   - ACCUM: accept on in_valid & in_ready. acc_out <= acc_out + zext(sum_in).
//     sample_cnt <= sample_cnt+1. On accepting sample BURST (sample_cnt==BURST-1):
//     -> HOLD. In that same edge out_valid<=1 and acc_out takes the final sum,
//     so the result is visible 1 cycle after the last sample.
//   - HOLD: out_valid=1. acc_out, overflow and sample_cnt (=BURST) are held
//     stable. On out_valid & out_ready & ena: -> ACCUM with acc_out<=0,
//     sample_cnt<=0, overflow<=0, out_valid<=0. The first new sample is
//     accepted no earlier than the next cycle.
//   Overflow: the sum is computed in ACC_W+1 bits. If the carry out is set,
//     overflow<=1 (sticky until the result is consumed or cleared).
//     SATURATE=1: acc_out<=all-ones, and further adds keep it all-ones.
//     SATURATE=0: acc_out<=low ACC_W bits.
//   clear (requires ena=1) has the highest priority in any state: acc_out<=0,
//     sample_cnt<=0, overflow<=0, out_valid<=0, ->ACCUM. A sample presented in
//     the same cycle is dropped (in_ready=0). A pending HOLD result is discarded.
//   ena=0: no state change in any state, including a pending handshake.
//     Outputs hold their values. in_ready=0. out_valid keeps its value.
//   Once out_valid=1, it never deasserts without a handshake, clear or reset.
//   The consumer may wait any number of cycles.
// TESTING
//   1 Reset mid-burst after 2 samples: rst_n=0 -> acc_out=0, sample_cnt=0,
//     out_valid=0 with no clk edge. After release, in_ready=1.
//   2 Defaults; feed 10,20,30,40 back-to-back with out_ready=0 -> out_valid=1
//     one cycle after the 40, acc_out=100, overflow=0, in_ready=0.
//   3 From HOLD (100): out_ready=0 for 5 cycles with in_valid=1, sum_in=7 ->
//     acc_out stays 100, no sample taken. Then out_ready=1 for 1 cycle ->
//     next cycle out_valid=0, acc_out=0, in_ready=1.
//   4 ACC_W=10, 4x sum_in=511: with SATURATE=1 -> acc_out=1023, overflow=1.
//     With SATURATE=0 -> acc_out=1020 (2044 mod 1024), overflow=1.
//   5 After samples 5,6, assert clear together with in_valid, sum_in=9 ->
//     acc_out=0, sample_cnt=0, 9 dropped. Next 4 samples of 1 -> acc_out=4.
//   6 Drop ena to 0 for 3 cycles mid-burst and in HOLD with out_ready=1 ->
//     no accepts, no handshake, all outputs frozen. Behaviour resumes when ena=1.

Source files
------------

// File: rtl/tt_sum_accumulator_if.sv
// Sample/result handshake bundle between the adder stage and the sum accumulator.
// The master drives samples and takes results; the slave is the accumulator itself.
interface tt_sum_accumulator_if #(
    parameter int IN_W  = 9,
    parameter int ACC_W = 11
);
    logic [IN_W-1:0]  sum_in;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;
    logic [7:0]       sample_cnt;

    modport master (
        output sum_in, in_valid, out_ready,
        input  in_ready, acc_out, out_valid, overflow, sample_cnt
    );

    modport slave (
        input  sum_in, in_valid, out_ready,
        output in_ready, acc_out, out_valid, overflow, sample_cnt
    );
endinterface

// File: rtl/tt_sum_accumulator.sv
// Integrates BURST consecutive adder samples into a wider result, then holds it
// behind a valid/ready output until consumed, flagging any overflow on the way.
module tt_sum_accumulator #(
    parameter int IN_W     = 9,
    parameter int ACC_W    = 11,
    parameter int BURST    = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  clear,
    tt_sum_accumulator_if.slave   bus
);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(BURST - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             out_valid_q;
    logic             overflow_q;

    logic [ACC_W:0]   sum_wide;
    logic             carry;
    logic [ACC_W-1:0] next_acc;
    logic             accept;

    // One extra bit catches the carry; saturation pins the value so later adds stay at all-ones.
    always_comb begin
        sum_wide = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.sum_in};
        carry    = sum_wide[ACC_W];
        next_acc = sum_wide[ACC_W-1:0];
        if (carry && SATURATE) begin
            next_acc = '1;
        end
    end

    assign bus.in_ready   = ena & (state == ACCUM) & ~clear;
    assign accept         = bus.in_valid & bus.in_ready;

    assign bus.acc_out    = acc;
    assign bus.out_valid  = out_valid_q;
    assign bus.overflow   = overflow_q;
    assign bus.sample_cnt = cnt;

    // clear outranks everything while enabled; with ena low nothing moves, not even a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (ena) begin
            if (clear) begin
                state       <= ACCUM;
                acc         <= '0;
                cnt         <= '0;
                out_valid_q <= 1'b0;
                overflow_q  <= 1'b0;
            end else begin
                case (state)
                    ACCUM: begin
                        if (accept) begin
                            acc <= next_acc;
                            cnt <= cnt + 8'd1;
                            if (carry) begin
                                overflow_q <= 1'b1;
                            end
                            if (cnt == LAST_CNT) begin
                                state       <= HOLD;
                                out_valid_q <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (out_valid_q && bus.out_ready) begin
                            state       <= ACCUM;
                            acc         <= '0;
                            cnt         <= '0;
                            out_valid_q <= 1'b0;
                            overflow_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ACCUM;
                    end
                endcase
            end
        end
    end

endmodule
